// File: rtl/riscv_pkg.sv
// Shared RISC-V load/store definitions: access codes, FSM states, size decode.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  // Load codes as presented on MemtoReg; bit 3 marks the zero-extending forms.
  localparam logic [3:0] LD_LB  = 4'b0001;
  localparam logic [3:0] LD_LH  = 4'b0011;
  localparam logic [3:0] LD_LW  = 4'b0101;
  localparam logic [3:0] LD_LBU = 4'b1001;
  localparam logic [3:0] LD_LHU = 4'b1011;

  // Store codes as presented on selStore.
  localparam logic [2:0] SEL_SB = 3'b000;
  localparam logic [2:0] SEL_SH = 3'b001;
  localparam logic [2:0] SEL_SW = 3'b010;

  // Access size in bytes for a load code; 0 flags an unrecognised code.
  function automatic logic [2:0] load_size(input logic [3:0] code);
    case (code)
      LD_LB, LD_LBU: load_size = 3'd1;
      LD_LH, LD_LHU: load_size = 3'd2;
      LD_LW:         load_size = 3'd4;
      default:       load_size = 3'd0;
    endcase
  endfunction

  // Access size in bytes for a store code; 0 flags an unrecognised code.
  function automatic logic [2:0] store_size(input logic [2:0] code);
    case (code)
      SEL_SB:  store_size = 3'd1;
      SEL_SH:  store_size = 3'd2;
      SEL_SW:  store_size = 3'd4;
      default: store_size = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Little-endian load result formatting: selects the valid bytes of the raw
// word and sign- or zero-extends them according to the load code.
module load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [3:0]  code,
  output logic [31:0] rdata
);

  // Pick width and extension from the load code; unknown codes yield zero.
  always_comb begin
    case (code)
      LD_LB:   rdata = {{24{raw[7]}}, raw[7:0]};
      LD_LH:   rdata = {{16{raw[15]}}, raw[15:0]};
      LD_LW:   rdata = raw;
      LD_LBU:  rdata = {24'd0, raw[7:0]};
      LD_LHU:  rdata = {16'd0, raw[15:0]};
      default: rdata = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial load/store unit: splits a lb/lh/lw/lbu/lhu/sb/sh/sw request into
// one byte-bus handshake per byte, assembles load data little-endian, and
// reports completion with a one-cycle done pulse (err for bad/misaligned ops).
module load_store_unit
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        MemRW,
  input  logic [3:0]  MemtoReg,
  input  logic [2:0]  selStore,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic        bus_ack,
  input  logic [7:0]  bus_rdata
);

  lsu_state_e  state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [1:0]  last_q, last_d;
  logic        we_q, we_d;
  logic [3:0]  code_q, code_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] raw_q, raw_d;
  logic [31:0] rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [7:0]  bus_wdata_q, bus_wdata_d;

  logic [2:0]  req_size;
  logic [2:0]  size_m1;
  logic        misalign;
  logic [1:0]  k_inc;
  logic [31:0] raw_next;
  logic [31:0] ext_rdata;

  // Final load formatting works on the raw word including the byte arriving
  // this cycle, so rdata is ready in the same cycle as done.
  load_extend u_load_extend (
    .raw   (raw_next),
    .code  (code_q),
    .rdata (ext_rdata)
  );

  // Request decode, byte-lane merge and next-state/next-output computation.
  always_comb begin
    req_size = MemRW ? store_size(selStore) : load_size(MemtoReg);
    size_m1  = req_size - 3'd1;
    misalign = ((req_size == 3'd2) && addr[0]) ||
               ((req_size == 3'd4) && (addr[1:0] != 2'b00));
    k_inc    = k_q + 2'd1;

    raw_next = raw_q;
    raw_next[{k_q, 3'b000} +: 8] = bus_rdata;

    state_d     = state_q;
    k_d         = k_q;
    last_d      = last_q;
    we_d        = we_q;
    code_d      = code_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    raw_d       = raw_q;
    rdata_d     = rdata_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if ((req_size == 3'd0) || misalign) begin
            // Rejected request: complete immediately, never touch the bus.
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end else begin
            state_d     = XFER;
            k_d         = 2'd0;
            last_d      = size_m1[1:0];
            we_d        = MemRW;
            code_d      = MemtoReg;
            addr_d      = addr;
            wdata_d     = wdata;
            raw_d       = 32'd0;
            bus_req_d   = 1'b1;
            bus_we_d    = MemRW;
            bus_addr_d  = addr;
            bus_wdata_d = wdata[7:0];
          end
        end
      end
      XFER: begin
        if (bus_ack) begin
          raw_d = raw_next;
          if (k_q == last_q) begin
            state_d     = DONE;
            done_d      = 1'b1;
            bus_req_d   = 1'b0;
            bus_we_d    = 1'b0;
            bus_addr_d  = 32'd0;
            bus_wdata_d = 8'd0;
            if (!we_q) begin
              rdata_d = ext_rdata;
            end
          end else begin
            // Address wraps naturally at 32 bits.
            k_d         = k_inc;
            bus_addr_d  = addr_q + {30'd0, k_inc};
            bus_wdata_d = wdata_q[{k_inc, 3'b000} +: 8];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        k_d     = 2'd0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= 2'd0;
      last_q      <= 2'd0;
      we_q        <= 1'b0;
      code_q      <= 4'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      raw_q       <= 32'd0;
      rdata_q     <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      last_q      <= last_d;
      we_q        <= we_d;
      code_q      <= code_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      raw_q       <= raw_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port start  input  1  one-cycle request strobe; accepted only while busy=0.
REQ-004 SHALL have port MemRW  input  1  1=store, 0=load; sampled at accepted start.
REQ-005 SHALL have port MemtoReg  input  4  load code: 0001 lb, 0011 lh, 0101 lw, 1001 lbu, 1011 lhu; sampled at start.
REQ-006 SHALL have port selStore  input  3  store code: 000 sb, 001 sh, 010 sw; sampled at start.
REQ-007 SHALL have port addr  input  32  byte address from ALU; sampled at start.
REQ-008 SHALL have port wdata  input  32  store data (rs2); sampled at start.
REQ-009 SHALL have outputs busy 1 (request in flight), done 1 (one-cycle completion pulse), err 1 (valid with done), rdata 32 (extended load result).
REQ-010 SHALL have byte-bus outputs bus_req 1, bus_we 1, bus_addr 32, bus_wdata 8, and inputs bus_ack 1, bus_rdata 8.

Function
REQ-011 SHALL decode size N: lb/lbu/sb=1, lh/lhu/sh=2, lw/sw=4; codes not listed in REQ-005/006 are invalid.
REQ-012 SHALL use states IDLE, XFER, DONE; busy=1 in XFER and DONE.
REQ-013 SHALL, on start in IDLE with valid code and natural alignment, go to XFER with byte counter k=0.
REQ-014 SHALL, on start with invalid code or misalignment (N=2 and addr[0]=1; N=4 and addr[1:0]!=0), go straight to DONE with no bus activity, err=1, and rdata=0.
REQ-015 SHALL, in XFER, drive bus_req=1, bus_we=stored MemRW, bus_addr=addr+k, bus_wdata=wdata[8k+7:8k], all held stable until bus_ack=1.
REQ-016 SHALL, on bus_ack in XFER, capture bus_rdata into byte lane k for a load, then increment k; after byte N-1, go to DONE.
REQ-017 SHALL ignore bus_ack outside XFER and ignore start while busy=1.
REQ-018 SHALL, in DONE, pulse done=1 for exactly one cycle, then return to IDLE.
REQ-019 SHALL present, for loads, rdata valid from the done cycle: little-endian assembly, signed codes sign-extend from bit 8N-1, and unsigned codes (MemtoReg[3]=1) zero-extend.
REQ-020 SHALL hold rdata until the next accepted start; for stores, rdata is left unchanged.
REQ-021 SHALL achieve, with bus_ack tied high, a latency of N+1 cycles from start to done; start is accepted again in the cycle after done.
REQ-022 SHALL wrap addr+k modulo 2^32 (addr FFFFFFFF + 1 = 00000000).

Reset
REQ-023 SHALL, when rst=1 at any edge (including mid-XFER), force IDLE, k=0, busy=0, done=0, err=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, and rdata=0.
REQ-024 SHALL abandon an in-flight transfer on reset with no completion pulse; a late bus_ack after reset is ignored.

Structure
REQ-025 SHALL take MemtoReg codes, selStore codes, and the state enum from the shared package riscv_pkg.
REQ-026 SHALL place load assembly and extension in one combinational sub-module load_extend (inputs: 32-bit raw, code; output: 32-bit rdata).

Verification
REQ-027 lb from 0x100 with bus_rdata=0x80 and ack tied high -> one bus cycle, done at cycle 2, rdata=FFFFFF80, err=0.
REQ-028 lhu from 0x202 with bytes 0x34, 0xF2 -> bus_addr 0x202 then 0x203, rdata=0000F234.
REQ-029 sw of 0xDEADBEEF to 0x300 with ack delayed 2 cycles per byte -> bus_wdata EF, BE, AD, DE at 0x300..0x303, each held until ack, and done after the 4th ack.
REQ-030 lw from 0x301, and separately selStore=011 -> no bus_req, and done with err=1 on the next cycle.
REQ-031 rst asserted mid-sw after 2 acks -> bus_req=0 and busy=0 next cycle, no done pulse; a subsequent lb completes normally.
REQ-032 start pulsed while busy and bus_ack pulsed in IDLE -> both ignored; the original transaction's data and done pulse are unaffected.
